// File: rtl/hub75_scan_ctrl_if.sv
// HUB75 scan controller bus: pixel-source read port plus panel pins (master = controller).
// Read data lags the address by one cycle; the panel side has no backpressure.
interface hub75_scan_ctrl_if #(
    parameter int hpixel_p   = 64,
    parameter int vpixel_p   = 64,
    parameter int bpp_p      = 8,
    parameter int segments_p = 2
);
    localparam int rows_p = vpixel_p / segments_p;

    logic                                    i_enable;
    logic [$clog2(hpixel_p*vpixel_p)-1:0]    o_rd_addr;
    logic [segments_p-1:0][2:0][bpp_p-1:0]   i_rd_data;
    logic [segments_p-1:0]                   o_r;
    logic [segments_p-1:0]                   o_g;
    logic [segments_p-1:0]                   o_b;
    logic                                    o_clk;
    logic                                    o_lat;
    logic                                    o_oe_n;
    logic [$clog2(rows_p)-1:0]               o_addr;
    logic                                    o_frame_done;
    logic                                    o_busy;

    modport master (
        input  i_enable, i_rd_data,
        output o_rd_addr, o_r, o_g, o_b, o_clk, o_lat, o_oe_n, o_addr,
               o_frame_done, o_busy
    );

    modport slave (
        output i_enable, i_rd_data,
        input  o_rd_addr, o_r, o_g, o_b, o_clk, o_lat, o_oe_n, o_addr,
               o_frame_done, o_busy
    );
endinterface

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan sequencer with BCM; plane = 2*hpixel_p+3+(base_oe_p<<p) cycles, registered outputs.
// No backpressure: pixel source must answer every address one cycle later.
module hub75_scan_ctrl #(
    parameter int hpixel_p   = 64,
    parameter int vpixel_p   = 64,
    parameter int bpp_p      = 8,
    parameter int segments_p = 2,
    parameter int base_oe_p  = 1
) (
    input logic               clk,
    input logic               rst_n,
    hub75_scan_ctrl_if.master bus
);
    localparam int rows_p = vpixel_p / segments_p;
    localparam int AW     = $clog2(hpixel_p * vpixel_p);
    localparam int RW     = $clog2(rows_p);
    localparam int CW     = $clog2(hpixel_p);
    localparam int PW     = (bpp_p > 1) ? $clog2(bpp_p) : 1;
    localparam int OEW    = bpp_p + $clog2(base_oe_p + 1);
    localparam int CNTW   = (OEW > CW + 1) ? OEW : CW + 1;

    typedef enum logic [2:0] {IDLE, PREFETCH, SHIFT, LATCH, DISPLAY} state_t;

    state_t             state;
    logic [RW-1:0]      row;
    logic [PW-1:0]      plane;
    logic [CNTW-1:0]    cnt;

    logic [CW-1:0]         col;
    logic [OEW-1:0]        oe_len;
    logic                  last_col;
    logic                  last_plane;
    logic                  last_row;
    logic                  oe_last;
    logic                  addr_ahead;
    logic [segments_p-1:0] pix_r;
    logic [segments_p-1:0] pix_g;
    logic [segments_p-1:0] pix_b;

    // SHIFT uses cnt[0] as the A/B phase and the upper bits as the column.
    assign col        = cnt[CW:1];
    assign oe_len     = OEW'(base_oe_p) << plane;
    assign last_col   = (col == CW'(hpixel_p - 1));
    assign last_plane = (plane == PW'(bpp_p - 1));
    assign last_row   = (row == RW'(rows_p - 1));
    assign oe_last    = (cnt == CNTW'(oe_len - OEW'(1)));
    assign addr_ahead = (int'(col) + 2 < hpixel_p);

    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        for (int s = 0; s < segments_p; s++) begin
            pix_r[s] = bus.i_rd_data[s][0][plane];
            pix_g[s] = bus.i_rd_data[s][1][plane];
            pix_b[s] = bus.i_rd_data[s][2][plane];
        end
    end

    function automatic logic [AW-1:0] pix_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return AW'({r, c});
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            row              <= '0;
            plane            <= '0;
            cnt              <= '0;
            bus.o_rd_addr    <= '0;
            bus.o_r          <= '0;
            bus.o_g          <= '0;
            bus.o_b          <= '0;
            bus.o_clk        <= 1'b0;
            bus.o_lat        <= 1'b0;
            bus.o_oe_n       <= 1'b1;
            bus.o_addr       <= '0;
            bus.o_frame_done <= 1'b0;
            bus.o_busy       <= 1'b0;
        end else begin
            bus.o_frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_enable) begin
                        state         <= PREFETCH;
                        row           <= '0;
                        plane         <= '0;
                        cnt           <= '0;
                        bus.o_rd_addr <= pix_addr('0, '0);
                        bus.o_busy    <= 1'b1;
                    end
                end
                PREFETCH: begin
                    if (cnt[0]) begin
                        state     <= SHIFT;
                        cnt       <= '0;
                        bus.o_r   <= pix_r;
                        bus.o_g   <= pix_g;
                        bus.o_b   <= pix_b;
                        bus.o_clk <= 1'b0;
                        if (hpixel_p > 1)
                            bus.o_rd_addr <= pix_addr(row, CW'(1));
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                SHIFT: begin
                    if (!cnt[0]) begin
                        bus.o_clk <= 1'b1;
                        cnt       <= cnt + CNTW'(1);
                    end else if (last_col) begin
                        state      <= LATCH;
                        cnt        <= '0;
                        bus.o_clk  <= 1'b0;
                        bus.o_lat  <= 1'b1;
                        bus.o_addr <= row;
                    end else begin
                        // Entering cycle A of col+1: its data is on i_rd_data now, prefetch col+2.
                        cnt       <= cnt + CNTW'(1);
                        bus.o_clk <= 1'b0;
                        bus.o_r   <= pix_r;
                        bus.o_g   <= pix_g;
                        bus.o_b   <= pix_b;
                        if (addr_ahead)
                            bus.o_rd_addr <= pix_addr(row, CW'(col + CW'(2)));
                    end
                end
                LATCH: begin
                    state      <= DISPLAY;
                    cnt        <= '0;
                    bus.o_lat  <= 1'b0;
                    bus.o_oe_n <= 1'b0;
                end
                DISPLAY: begin
                    if (oe_last) begin
                        bus.o_oe_n <= 1'b1;
                        cnt        <= '0;
                        if (!last_plane) begin
                            plane         <= PW'(plane + PW'(1));
                            state         <= PREFETCH;
                            bus.o_rd_addr <= pix_addr(row, '0);
                        end else if (!last_row) begin
                            plane         <= '0;
                            row           <= RW'(row + RW'(1));
                            state         <= PREFETCH;
                            bus.o_rd_addr <= pix_addr(RW'(row + RW'(1)), '0);
                        end else begin
                            plane            <= '0;
                            row              <= '0;
                            bus.o_frame_done <= 1'b1;
                            if (bus.i_enable) begin
                                state         <= PREFETCH;
                                bus.o_rd_addr <= pix_addr('0, '0);
                            end else begin
                                state      <= IDLE;
                                bus.o_busy <= 1'b0;
                                bus.o_r    <= '0;
                                bus.o_g    <= '0;
                                bus.o_b    <= '0;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl in a 4x4, 2-plane, 2-segment, base-2 configuration.
module tb_hub75_scan_ctrl;
    localparam int H    = 4;
    localparam int V    = 4;
    localparam int BPP  = 2;
    localparam int SEG  = 2;
    localparam int BASE = 2;
    localparam int ROWS = V / SEG;
    localparam int FRAME = ROWS * (BPP * (2 * H + 3) + BASE * ((1 << BPP) - 1));

    typedef logic [SEG-1:0][2:0][BPP-1:0] pix_t;

    logic clk;
    logic rst_n;

    hub75_scan_ctrl_if #(.hpixel_p(H), .vpixel_p(V), .bpp_p(BPP), .segments_p(SEG)) bus ();

    hub75_scan_ctrl #(
        .hpixel_p(H), .vpixel_p(V), .bpp_p(BPP), .segments_p(SEG), .base_oe_p(BASE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pix_t src(input int a);
        pix_t p;
        for (int s = 0; s < SEG; s++)
            for (int ch = 0; ch < 3; ch++)
                p[s][ch] = BPP'(a * 3 + 5 * s + ch);
        return p;
    endfunction

    // Registered pixel source: address in cycle t answered in cycle t+1.
    always @(posedge clk) bus.i_rd_data <= src(int'(bus.o_rd_addr));

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [5:0] shift_q[$];
    int         lat_q[$];
    int         oe_q[$];
    logic       prev_clk;
    logic       prev_oe_n;
    int         oe_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame();
        pix_t       p;
        logic [1:0] r, g, b;
        for (int row = 0; row < ROWS; row++)
            for (int pl = 0; pl < BPP; pl++) begin
                for (int c = 0; c < H; c++) begin
                    p = src(row * H + c);
                    for (int s = 0; s < SEG; s++) begin
                        r[s] = p[s][0][pl];
                        g[s] = p[s][1][pl];
                        b[s] = p[s][2][pl];
                    end
                    shift_q.push_back({r, g, b});
                end
                lat_q.push_back(row);
                oe_q.push_back(BASE << pl);
            end
    endtask

    task automatic flush_sb();
        shift_q.delete();
        lat_q.delete();
        oe_q.delete();
    endtask

    // One cycle: sample away from the active edge and pop/compare the scoreboard.
    task automatic tick();
        @(negedge clk);
        if (!rst_n) begin
            prev_clk  = 1'b0;
            prev_oe_n = 1'b1;
            oe_run    = 0;
        end else begin
            if (bus.o_clk && !prev_clk) begin
                chk("shift_expected", 32'(shift_q.size() != 0), 32'd1);
                if (shift_q.size() != 0)
                    chk("shift_bits", 32'({bus.o_r, bus.o_g, bus.o_b}), 32'(shift_q.pop_front()));
            end
            if (bus.o_lat) begin
                chk("lat_clk_low", 32'(bus.o_clk), 32'd0);
                chk("lat_expected", 32'(lat_q.size() != 0), 32'd1);
                if (lat_q.size() != 0)
                    chk("lat_row_addr", 32'(bus.o_addr), 32'(lat_q.pop_front()));
            end
            if (!bus.o_oe_n) oe_run++;
            if (bus.o_oe_n && !prev_oe_n) begin
                chk("oe_expected", 32'(oe_q.size() != 0), 32'd1);
                if (oe_q.size() != 0)
                    chk("oe_run_len", 32'(oe_run), 32'(oe_q.pop_front()));
                oe_run = 0;
            end
            prev_clk  = bus.o_clk;
            prev_oe_n = bus.o_oe_n;
        end
    endtask

    task automatic run_to_fd(input int max_cyc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.o_frame_done && n < max_cyc);
        if (!bus.o_frame_done) chk("frame_done_timeout", 32'(n), 32'(max_cyc + 1));
    endtask

    task automatic check_idle_pins(input string tag);
        chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        chk({tag, "_oe_n"}, 32'(bus.o_oe_n), 32'd1);
        chk({tag, "_clk"}, 32'(bus.o_clk), 32'd0);
        chk({tag, "_lat"}, 32'(bus.o_lat), 32'd0);
    endtask

    int n;
    int fd_cnt;

    initial begin
        prev_clk  = 1'b0;
        prev_oe_n = 1'b1;
        oe_run    = 0;

        // Reset held with enable asserted.
        rst_n        = 1'b0;
        bus.i_enable = 1'b1;
        repeat (3) tick();
        check_idle_pins("reset");
        chk("reset_rd_addr", 32'(bus.o_rd_addr), 32'd0);
        chk("reset_addr", 32'(bus.o_addr), 32'd0);
        chk("reset_frame_done", 32'(bus.o_frame_done), 32'd0);
        chk("reset_rgb", 32'({bus.o_r, bus.o_g, bus.o_b}), 32'd0);

        // Continuous scan: first frame latency then steady period.
        rst_n = 1'b1;
        push_frame();
        run_to_fd(200, n);
        chk("first_frame_cycles", 32'(n), 32'(FRAME + 1));
        chk("busy_running", 32'(bus.o_busy), 32'd1);
        push_frame();
        run_to_fd(200, n);
        chk("frame_period", 32'(n), 32'(FRAME));

        // Enable dropped mid-frame: current frame still completes, then idle.
        push_frame();
        repeat (20) tick();
        bus.i_enable = 1'b0;
        run_to_fd(200, n);
        chk("drop_frame_rest", 32'(n), 32'(FRAME - 20));
        chk("drop_busy_at_done", 32'(bus.o_busy), 32'd0);
        fd_cnt = 0;
        repeat (60) begin
            tick();
            if (bus.o_frame_done) fd_cnt++;
        end
        chk("idle_no_frame_done", 32'(fd_cnt), 32'd0);
        check_idle_pins("idle");
        chk("sb_shift_drained", 32'(shift_q.size()), 32'd0);
        chk("sb_lat_drained", 32'(lat_q.size()), 32'd0);
        chk("sb_oe_drained", 32'(oe_q.size()), 32'd0);

        // Reset during DISPLAY of row 1 aborts immediately; restart begins at row 0 plane 0.
        bus.i_enable = 1'b1;
        push_frame();
        n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.o_addr == 1'b1 && !bus.o_oe_n) && n < 200);
        chk("reached_row1_display", 32'(!bus.o_oe_n && bus.o_addr == 1'b1), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("abort_oe_n", 32'(bus.o_oe_n), 32'd1);
        chk("abort_addr", 32'(bus.o_addr), 32'd0);
        chk("abort_busy", 32'(bus.o_busy), 32'd0);
        tick();
        flush_sb();
        rst_n = 1'b1;
        push_frame();
        run_to_fd(200, n);
        chk("restart_frame_cycles", 32'(n), 32'(FRAME + 1));
        chk("restart_shift_drained", 32'(shift_q.size()), 32'd0);
        chk("restart_lat_drained", 32'(lat_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
